inst_seg_display: RTL and testbench
===================================

Name: inst_seg_display

Overview:
- Downstream consumer of the single-cycle computer's debug outputs (pc, inst). Drives an 8-digit common-anode seven-segment display on the board.
- Latches either pc or inst once per scan frame (tear-free), then time-multiplexes the eight hex nibbles.
- Includes per-digit anti-ghost blanking.
- Pure sequential display back-end; no feedback into the CPU.

Parameters:
- SCAN_DIV, 100000: clk cycles per digit slot; legal range >= 2.
- BLANK_CYCLES, 16: cycles at the start of each slot during which all anodes are off; legal range 1 .. SCAN_DIV-1.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous, active-low reset.
- pc  in  32  current PC from the computer.
- inst  in  32  current instruction from the computer.
- sel  in  1  0: display inst, 1: display pc.
- freeze  in  1  1: hold the current shadow value (no new frame latch).
- an  out  8  anode enables, active-low; an[0] is the rightmost digit.
- seg  out  8  cathodes, active-low; seg[6:0] = gfedcba, seg[7] = dp.

Behaviour:
- Reset (rst=0, asynchronous): an=8'hFF, seg=8'hFF, prescaler=0, digit index d=0, shadow=0, mode=0. Asserting reset mid-scan blanks the display immediately.
- Prescaler counts 0..SCAN_DIV-1 and wraps to 0. tick=1 when prescaler==SCAN_DIV-1.
- On tick, d increments, wrapping 7->0.
- Frame latch: on tick with d==7 and freeze=0, shadow <= (sel ? pc : inst) and mode <= sel.
  - With freeze=1, shadow and mode hold.
  - sel/pc/inst changes mid-frame take effect only at the next frame boundary.
- Digit d shows nibble shadow[4d+3:4d]. Decode is active-low: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E (seg[7]=1 in all codes).
- Decimal point: seg[7]=0 on digit 7 only when mode=1 (pc shown). Otherwise seg[7]=1.
- an and seg are registered:
  - When prescaler < BLANK_CYCLES: an=8'hFF, seg=8'hFF.
  - Otherwise: an = ~(8'b1 << d), seg = decode of the current nibble.
  - Outputs reflect the prescaler/d values of the previous cycle (1-cycle latency).
- Full frame period = 8*SCAN_DIV cycles. The first frame after reset displays shadow=0, i.e. "00000000", with dp off.
- Exactly one anode is ever low at a time. No anode is low during a blank window.

Optional Feature:
- Macro: SEG_BLANK_LEADING_EN.
- Defined: digits above the most-significant non-zero nibble of shadow are blanked (seg[6:0]=7'h7F; anode still driven). Digit 0 always shows, so value 0 displays a single "0". The digit-7 dp rule still applies (seg=8'h7F on a blanked digit 7 in pc mode).
- Undefined: all eight digits are always shown, including leading zeros.

Decomposition:
- Shared package seg_pkg: the 16-entry active-low hex pattern constants, SEG_OFF=8'hFF, and DIGITS=8.
- One sub-module: hex7seg (4-bit nibble in, 7-bit active-low pattern out, combinational), instantiated once and fed by the digit mux.

Test Plan (bench uses SCAN_DIV=4, BLANK_CYCLES=1):
- Reset: rst=0 held mid-scan -> an=FF, seg=FF within the same cycle. After release, first frame shows C0 on every digit slot.
- Instruction mode: sel=0, inst=32'h12345678, wait one frame boundary -> digit 0 slot shows an=FE seg=80; digit 7 slot shows an=7F seg=F9. The cycle at each slot start shows an=FF.
- PC mode: sel=1, pc=32'h00400000 -> digit 5 slot shows seg=99; digit 7 slot shows seg=40 (0 with dp); digit 0 slot shows seg=C0.
- Mid-frame change: switch inst 32'h0000000F -> 32'hFFFFFFFF at d=3 -> remainder of the current frame still shows shadow 0000000F; next frame digit 7 shows seg=8E.
- Freeze: freeze=1, change inst to 32'hDEADBEEF for 3 frames -> display unchanged. After freeze=0, next frame digit 0 shows seg=8E and digit 7 shows seg=A1.
- SEG_BLANK_LEADING_EN defined, inst=32'h000000A0 -> digits 2..7 show seg=FF, digit 1 shows seg=88, digit 0 shows seg=C0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display back-end: active-low hex glyphs and display geometry.
// Combinational only; no latency, no backpressure.
package seg_pkg;

    localparam int DIGITS = 8;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Entry n is the active-low gfedcba pattern for hex digit n, dp bit (7) high.
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    // Index of the most-significant non-zero nibble; 0 when the value is zero.
    function automatic logic [2:0] top_nibble(input logic [31:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 1; i < DIGITS; i++) begin
            if (v[4*i +: 4] != 4'h0) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/inst_seg_display_if.sv
// Debug-value inputs from the CPU and the multiplexed anode/cathode outputs to the board.
// Plain wires; no flow control (the display consumes values continuously).
interface inst_seg_display_if;
    import seg_pkg::*;

    logic [31:0]       pc;
    logic [31:0]       inst;
    logic              sel;
    logic              freeze;
    logic [DIGITS-1:0] an;
    logic [7:0]        seg;

    modport master (output pc, inst, sel, freeze, input an, seg);
    modport slave  (input pc, inst, sel, freeze, output an, seg);

endinterface

// File: rtl/hex7seg.sv
// Hex nibble to active-low gfedcba pattern.
// Combinational, zero latency, no backpressure.
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] pat
);

    assign pat = HEX_SEG[nib][6:0];

endmodule

// File: rtl/inst_seg_display.sv
// Tear-free 8-digit scanner for pc/inst with anti-ghost blanking; optional SEG_BLANK_LEADING_EN hides leading zeros.
// Outputs registered, 1-cycle latency from prescaler/digit state; no backpressure.
module inst_seg_display
    import seg_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    inst_seg_display_if.slave  bus
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);

    logic [PW-1:0]     presc;
    logic [2:0]        d;
    logic [31:0]       shadow;
    logic              mode;
    logic              tick;
    logic [3:0]        nib;
    logic [6:0]        pat;
    logic              blank_lead;
    logic [DIGITS-1:0] an_q, an_nxt;
    logic [7:0]        seg_q, seg_nxt;

    assign tick = (presc == PRESC_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
            d     <= 3'd0;
        end else if (tick) begin
            presc <= '0;
            d     <= d + 3'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Shadow only changes on the last tick of a frame so a frame never mixes two values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow <= 32'd0;
            mode   <= 1'b0;
        end else if (tick && d == 3'd7 && !bus.freeze) begin
            shadow <= bus.sel ? bus.pc : bus.inst;
            mode   <= bus.sel;
        end
    end

    assign nib = shadow[{d, 2'b00} +: 4];

    hex7seg u_hex7seg (
        .nib (nib),
        .pat (pat)
    );

`ifdef SEG_BLANK_LEADING_EN
    assign blank_lead = (d > top_nibble(shadow));
`else
    assign blank_lead = 1'b0;
`endif

    always_comb begin
        an_nxt  = SEG_OFF;
        seg_nxt = SEG_OFF;
        if (presc >= BLANK_END) begin
            an_nxt  = ~(8'd1 << d);
            seg_nxt = {~(mode && d == 3'd7), blank_lead ? 7'h7F : pat};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_q  <= SEG_OFF;
            seg_q <= SEG_OFF;
        end else begin
            an_q  <= an_nxt;
            seg_q <= seg_nxt;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;

endmodule

// File: tb/tb_inst_seg_display.sv
// Randomised self-checking bench for inst_seg_display against a frame/slot time-index model.
module tb_inst_seg_display;

    localparam int SD    = 4;
    localparam int BC    = 1;
    localparam int FRAME = 8 * SD;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    inst_seg_display_if bus();

    inst_seg_display #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          k        = 0;
    logic [31:0] shadow_m = 32'd0;
    logic        mode_m   = 1'b0;
    int          m_presc, m_d;
    logic [7:0]  exp_an, exp_seg;
    logic [7:0]  hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

`ifdef SEG_BLANK_LEADING_EN
    localparam bit LEAD = 1'b1;
`else
    localparam bit LEAD = 1'b0;
`endif

    function automatic logic [7:0] ref_seg(input logic [31:0] v, input logic m, input int dig);
        logic [7:0] s;
        int         lead;
        s    = hex_tab[int'((v >> (4 * dig)) & 32'hF)];
        lead = 0;
        for (int i = 0; i < 8; i++) if (((v >> (4 * i)) & 32'hF) != 0) lead = i;
        if (LEAD && dig > lead) s = 8'hFF;
        if (m && dig == 7) s[7] = 1'b0;
        return s;
    endfunction

    // One clock: the model's expectation for the outputs after this edge comes from the
    // slot position of the cycle just ended; the frame value updates at each frame end.
    task automatic cycle();
        logic [31:0] c_pc, c_inst;
        logic        c_sel, c_frz;
        c_pc = bus.pc; c_inst = bus.inst; c_sel = bus.sel; c_frz = bus.freeze;
        @(posedge clk);
        m_presc = k % SD;
        m_d     = (k / SD) % 8;
        if (m_presc < BC) begin
            exp_an  = 8'hFF;
            exp_seg = 8'hFF;
        end else begin
            exp_an  = ~(8'd1 << m_d);
            exp_seg = ref_seg(shadow_m, mode_m, m_d);
        end
        if (k % FRAME == FRAME - 1 && !c_frz) begin
            shadow_m = c_sel ? c_pc : c_inst;
            mode_m   = c_sel;
        end
        k++;
        #1;
    endtask

    task automatic run_to_boundary();
        do cycle(); while (k % FRAME != 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
        k = 0; shadow_m = 32'd0; mode_m = 1'b0;
    endtask

    task automatic test_reset();
        bus.pc = 32'd0; bus.inst = 32'h12345678; bus.sel = 1'b0; bus.freeze = 1'b0;
        #12;
        n_checks++;
        if (bus.an !== 8'hFF || bus.seg !== 8'hFF) begin
            n_fail++; $display("FAIL reset_hold: an=%h seg=%h required an=ff seg=ff", bus.an, bus.seg);
        end
        release_reset();
        for (int i = 0; i < FRAME; i++) begin
            cycle();
            n_checks++;
            if (bus.an !== exp_an || bus.seg !== exp_seg) begin
                n_fail++; $display("FAIL first_frame k=%0d: an=%h seg=%h required an=%h seg=%h", k, bus.an, bus.seg, exp_an, exp_seg);
            end
            if (m_presc >= BC) begin
                n_checks++;
                if (bus.seg !== 8'hC0) begin
                    n_fail++; $display("FAIL first_frame_zero d=%0d: seg=%h required seg=c0", m_d, bus.seg);
                end
            end
        end
        repeat (10) cycle();
        n_checks++;
        if (bus.an !== exp_an || exp_an === 8'hFF) begin
            n_fail++; $display("FAIL pre_reset_active: an=%h required an=%h (lit)", bus.an, exp_an);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (bus.an !== 8'hFF || bus.seg !== 8'hFF) begin
            n_fail++; $display("FAIL reset_async: an=%h seg=%h required an=ff seg=ff", bus.an, bus.seg);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.an !== 8'hFF || bus.seg !== 8'hFF) begin
            n_fail++; $display("FAIL reset_held_clocked: an=%h seg=%h required an=ff seg=ff", bus.an, bus.seg);
        end
        release_reset();
    endtask

    task automatic test_inst_mode();
        bus.sel = 1'b0; bus.inst = 32'h12345678; bus.freeze = 1'b0;
        run_to_boundary();
        for (int i = 0; i < FRAME; i++) begin
            cycle();
            n_checks++;
            if (bus.an !== exp_an || bus.seg !== exp_seg) begin
                n_fail++; $display("FAIL inst_frame k=%0d: an=%h seg=%h required an=%h seg=%h", k, bus.an, bus.seg, exp_an, exp_seg);
            end
            if (m_presc == 0) begin
                n_checks++;
                if (bus.an !== 8'hFF) begin
                    n_fail++; $display("FAIL inst_slot_blank d=%0d: an=%h required an=ff", m_d, bus.an);
                end
            end else if (m_d == 0) begin
                n_checks++;
                if (bus.an !== 8'hFE || bus.seg !== 8'h80) begin
                    n_fail++; $display("FAIL inst_digit0: an=%h seg=%h required an=fe seg=80", bus.an, bus.seg);
                end
            end else if (m_d == 7) begin
                n_checks++;
                if (bus.an !== 8'h7F || bus.seg !== 8'hF9) begin
                    n_fail++; $display("FAIL inst_digit7: an=%h seg=%h required an=7f seg=f9", bus.an, bus.seg);
                end
            end
        end
    endtask

    task automatic test_pc_mode();
        logic [7:0] d7_exp;
        d7_exp = LEAD ? 8'h7F : 8'h40;
        bus.sel = 1'b1; bus.pc = 32'h00400000; bus.inst = $urandom;
        run_to_boundary();
        for (int i = 0; i < FRAME; i++) begin
            cycle();
            n_checks++;
            if (bus.an !== exp_an || bus.seg !== exp_seg) begin
                n_fail++; $display("FAIL pc_frame k=%0d: an=%h seg=%h required an=%h seg=%h", k, bus.an, bus.seg, exp_an, exp_seg);
            end
            if (m_presc >= BC && (m_d == 5 || m_d == 7 || m_d == 0)) begin
                n_checks++;
                if (bus.seg !== (m_d == 5 ? 8'h99 : m_d == 7 ? d7_exp : 8'hC0)) begin
                    n_fail++; $display("FAIL pc_digit%0d: seg=%h required seg=%h", m_d, bus.seg,
                                       (m_d == 5 ? 8'h99 : m_d == 7 ? d7_exp : 8'hC0));
                end
            end
        end
    endtask

    task automatic test_mid_frame();
        logic [7:0] d7_old;
        d7_old = LEAD ? 8'hFF : 8'hC0;
        bus.sel = 1'b0; bus.inst = 32'h0000000F;
        run_to_boundary();
        for (int i = 0; i < FRAME; i++) begin
            cycle();
            if (m_d == 3 && m_presc == 0) bus.inst = 32'hFFFFFFFF;
            n_checks++;
            if (bus.an !== exp_an || bus.seg !== exp_seg) begin
                n_fail++; $display("FAIL mid_frame k=%0d: an=%h seg=%h required an=%h seg=%h", k, bus.an, bus.seg, exp_an, exp_seg);
            end
            if (m_d == 7 && m_presc >= BC) begin
                n_checks++;
                if (bus.seg !== d7_old) begin
                    n_fail++; $display("FAIL mid_frame_hold: seg=%h required seg=%h", bus.seg, d7_old);
                end
            end
        end
        for (int i = 0; i < FRAME; i++) begin
            cycle();
            if (m_d == 7 && m_presc >= BC) begin
                n_checks++;
                if (bus.seg !== 8'h8E) begin
                    n_fail++; $display("FAIL mid_frame_next: seg=%h required seg=8e", bus.seg);
                end
            end
        end
    endtask

    task automatic test_freeze();
        bus.freeze = 1'b1; bus.inst = 32'hDEADBEEF;
        for (int i = 0; i < 3 * FRAME; i++) begin
            cycle();
            n_checks++;
            if (bus.an !== exp_an || bus.seg !== exp_seg) begin
                n_fail++; $display("FAIL freeze_frame k=%0d: an=%h seg=%h required an=%h seg=%h", k, bus.an, bus.seg, exp_an, exp_seg);
            end
            if (m_presc >= BC) begin
                n_checks++;
                if (bus.seg !== 8'h8E) begin
                    n_fail++; $display("FAIL freeze_hold d=%0d: seg=%h required seg=8e", m_d, bus.seg);
                end
            end
        end
        bus.freeze = 1'b0;
        run_to_boundary();
        for (int i = 0; i < FRAME; i++) begin
            cycle();
            if (m_presc >= BC && (m_d == 0 || m_d == 7)) begin
                n_checks++;
                if (bus.seg !== (m_d == 0 ? 8'h8E : 8'hA1)) begin
                    n_fail++; $display("FAIL unfreeze_digit%0d: seg=%h required seg=%h", m_d, bus.seg, (m_d == 0 ? 8'h8E : 8'hA1));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6 * FRAME; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                bus.pc     = $urandom;
                bus.inst   = ($urandom_range(0, 1) != 0) ? $urandom : ($urandom >> (4 * $urandom_range(0, 7)));
                bus.sel    = 1'($urandom_range(0, 1));
                bus.freeze = ($urandom_range(0, 3) == 0);
            end
            cycle();
            n_checks++;
            if (bus.an !== exp_an || bus.seg !== exp_seg) begin
                n_fail++; $display("FAIL random k=%0d: an=%h seg=%h required an=%h seg=%h", k, bus.an, bus.seg, exp_an, exp_seg);
            end
            if ($countones(~bus.an) > 1) begin
                n_fail++; $display("FAIL one_anode k=%0d: an=%h required at most one low", k, bus.an);
            end
        end
        bus.freeze = 1'b0;
    endtask

    task automatic test_leading();
        logic [7:0] hi_exp;
        hi_exp = LEAD ? 8'hFF : 8'hC0;
        bus.sel = 1'b0; bus.inst = 32'h000000A0; bus.freeze = 1'b0;
        run_to_boundary();
        for (int i = 0; i < FRAME; i++) begin
            cycle();
            if (m_presc >= BC) begin
                n_checks++;
                if (bus.seg !== (m_d >= 2 ? hi_exp : m_d == 1 ? 8'h88 : 8'hC0)) begin
                    n_fail++; $display("FAIL leading d=%0d: seg=%h required seg=%h", m_d, bus.seg,
                                       (m_d >= 2 ? hi_exp : m_d == 1 ? 8'h88 : 8'hC0));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_inst_mode();
        test_pc_mode();
        test_mid_frame();
        test_freeze();
        test_random();
        test_leading();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
